// File: rtl/mpu6050_i2c_slave.sv
// MPU6050-compatible I2C target: config registers R/W, sensor words read-only.
// Filtered SCL/SDA front end feeding a byte-level transaction FSM.
`timescale 1ns/1ps
module mpu6050_i2c_slave #(
    parameter logic [6:0] DEV_ADDR     = 7'h68,
    parameter logic [7:0] WHO_AM_I_VAL = 8'h68,
    parameter int         FILT_LEN     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl,
    inout  wire         sda,
    input  logic [15:0] acc_x,
    input  logic [15:0] acc_y,
    input  logic [15:0] acc_z,
    input  logic [15:0] temp,
    input  logic [15:0] gyro_x,
    input  logic [15:0] gyro_y,
    input  logic [15:0] gyro_z,
    output logic [7:0]  smplrt_div,
    output logic [7:0]  config_reg,
    output logic [7:0]  gyro_config,
    output logic [7:0]  acc_config,
    output logic [7:0]  pwr_mgmt_1,
    output logic        wr_strobe,
    output logic [7:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy
);

    localparam logic [3:0] FILT_MAX = 4'(FILT_LEN - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_DEV_ADDR,
        S_ADDR_ACK,
        S_REG_ADDR,
        S_REG_ACK,
        S_WR_DATA,
        S_WR_ACK,
        S_RD_DATA,
        S_RD_ACK
    } state_t;

    logic [1:0]   scl_sync, sda_sync;
    logic [3:0]   scl_cnt, sda_cnt;
    logic         scl_f, sda_f, scl_d, sda_d;
    logic         scl_rise, scl_fall, start_c, stop_c;

    state_t       state;
    logic [3:0]   bit_cnt;
    logic [7:0]   shreg, tx, ptr;
    logic         rw, m_ack, sda_oe;
    logic [15:0]  snap_ax, snap_ay, snap_az, snap_t;
    logic [15:0]  snap_gx, snap_gy, snap_gz;
    logic [7:0]   rd_byte, rx_byte;

    // Open-drain: only ever pull low.
    assign sda = sda_oe ? 1'b0 : 1'bz;

    assign scl_rise = scl_f & ~scl_d;
    assign scl_fall = ~scl_f & scl_d;
    assign start_c  = sda_d & ~sda_f & scl_f & scl_d;
    assign stop_c   = ~sda_d & sda_f & scl_f & scl_d;
    assign rx_byte  = {shreg[6:0], sda_f};

    // Two-flop sync then a stability filter per line; levels delayed for edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_cnt  <= '0;
            sda_cnt  <= '0;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda};
            scl_d    <= scl_f;
            sda_d    <= sda_f;
            if (scl_sync[1] == scl_f) begin
                scl_cnt <= '0;
            end else if (scl_cnt == FILT_MAX) begin
                scl_f   <= scl_sync[1];
                scl_cnt <= '0;
            end else begin
                scl_cnt <= scl_cnt + 4'd1;
            end
            if (sda_sync[1] == sda_f) begin
                sda_cnt <= '0;
            end else if (sda_cnt == FILT_MAX) begin
                sda_f   <= sda_sync[1];
                sda_cnt <= '0;
            end else begin
                sda_cnt <= sda_cnt + 4'd1;
            end
        end
    end

    // Read mux: register at the pointer, sensor bytes from the snapshot.
    always_comb begin
        rd_byte = 8'h00;
        case (ptr)
            8'h19:   rd_byte = smplrt_div;
            8'h1A:   rd_byte = config_reg;
            8'h1B:   rd_byte = gyro_config;
            8'h1C:   rd_byte = acc_config;
            8'h3B:   rd_byte = snap_ax[15:8];
            8'h3C:   rd_byte = snap_ax[7:0];
            8'h3D:   rd_byte = snap_ay[15:8];
            8'h3E:   rd_byte = snap_ay[7:0];
            8'h3F:   rd_byte = snap_az[15:8];
            8'h40:   rd_byte = snap_az[7:0];
            8'h41:   rd_byte = snap_t[15:8];
            8'h42:   rd_byte = snap_t[7:0];
            8'h43:   rd_byte = snap_gx[15:8];
            8'h44:   rd_byte = snap_gx[7:0];
            8'h45:   rd_byte = snap_gy[15:8];
            8'h46:   rd_byte = snap_gy[7:0];
            8'h47:   rd_byte = snap_gz[15:8];
            8'h48:   rd_byte = snap_gz[7:0];
            8'h6B:   rd_byte = pwr_mgmt_1;
            8'h75:   rd_byte = WHO_AM_I_VAL;
            default: rd_byte = 8'h00;
        endcase
    end

    // Transaction FSM: bits sampled on SCL rise, SDA changed on SCL fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            tx          <= '0;
            ptr         <= '0;
            rw          <= 1'b0;
            m_ack       <= 1'b0;
            sda_oe      <= 1'b0;
            busy        <= 1'b0;
            wr_strobe   <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            smplrt_div  <= '0;
            config_reg  <= '0;
            gyro_config <= '0;
            acc_config  <= '0;
            pwr_mgmt_1  <= 8'h40;
            snap_ax     <= '0;
            snap_ay     <= '0;
            snap_az     <= '0;
            snap_t      <= '0;
            snap_gx     <= '0;
            snap_gy     <= '0;
            snap_gz     <= '0;
        end else begin
            wr_strobe <= 1'b0;
            if (start_c) begin
                state   <= S_DEV_ADDR;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else if (stop_c) begin
                state   <= S_IDLE;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else if (scl_rise) begin
                case (state)
                    S_DEV_ADDR, S_REG_ADDR: begin
                        if (bit_cnt < 4'd8) begin
                            shreg   <= rx_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    S_WR_DATA: begin
                        if (bit_cnt < 4'd8) begin
                            shreg   <= rx_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                        if (bit_cnt == 4'd7) begin
                            wr_strobe <= 1'b1;
                            wr_addr   <= ptr;
                            wr_data   <= rx_byte;
                            ptr       <= ptr + 8'd1;
                            case (ptr)
                                8'h19: smplrt_div  <= rx_byte;
                                8'h1A: config_reg  <= rx_byte;
                                8'h1B: gyro_config <= rx_byte;
                                8'h1C: acc_config  <= rx_byte;
                                8'h6B: begin
                                    if (rx_byte[7]) begin
                                        smplrt_div  <= '0;
                                        config_reg  <= '0;
                                        gyro_config <= '0;
                                        acc_config  <= '0;
                                        pwr_mgmt_1  <= 8'h40;
                                    end else begin
                                        pwr_mgmt_1  <= rx_byte;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                    S_RD_DATA: begin
                        if (bit_cnt < 4'd8) bit_cnt <= bit_cnt + 4'd1;
                    end
                    S_RD_ACK: m_ack <= ~sda_f;
                    default: ;
                endcase
            end else if (scl_fall) begin
                case (state)
                    S_DEV_ADDR: begin
                        if (bit_cnt == 4'd8) begin
                            if (shreg[7:1] == DEV_ADDR) begin
                                sda_oe <= 1'b1;
                                busy   <= 1'b1;
                                rw     <= shreg[0];
                                state  <= S_ADDR_ACK;
                                if (shreg[0]) begin
                                    snap_ax <= acc_x;
                                    snap_ay <= acc_y;
                                    snap_az <= acc_z;
                                    snap_t  <= temp;
                                    snap_gx <= gyro_x;
                                    snap_gy <= gyro_y;
                                    snap_gz <= gyro_z;
                                end
                            end else begin
                                state <= S_IDLE;
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        bit_cnt <= '0;
                        if (rw) begin
                            tx     <= rd_byte;
                            sda_oe <= ~rd_byte[7];
                            ptr    <= ptr + 8'd1;
                            state  <= S_RD_DATA;
                        end else begin
                            sda_oe <= 1'b0;
                            state  <= S_REG_ADDR;
                        end
                    end
                    S_REG_ADDR: begin
                        if (bit_cnt == 4'd8) begin
                            ptr    <= shreg;
                            sda_oe <= 1'b1;
                            state  <= S_REG_ACK;
                        end
                    end
                    S_REG_ACK, S_WR_ACK: begin
                        sda_oe  <= 1'b0;
                        bit_cnt <= '0;
                        state   <= S_WR_DATA;
                    end
                    S_WR_DATA: begin
                        if (bit_cnt == 4'd8) begin
                            sda_oe <= 1'b1;
                            state  <= S_WR_ACK;
                        end
                    end
                    S_RD_DATA: begin
                        if (bit_cnt == 4'd8) begin
                            sda_oe <= 1'b0;
                            state  <= S_RD_ACK;
                        end else begin
                            tx     <= {tx[6:0], 1'b0};
                            sda_oe <= ~tx[6];
                        end
                    end
                    S_RD_ACK: begin
                        bit_cnt <= '0;
                        if (m_ack) begin
                            tx     <= rd_byte;
                            sda_oe <= ~rd_byte[7];
                            ptr    <= ptr + 8'd1;
                            state  <= S_RD_DATA;
                        end else begin
                            sda_oe <= 1'b0;
                            state  <= S_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mpu6050_i2c_slave.sv
// Directed bench for mpu6050_i2c_slave: bit-banged I2C master,
// per-scenario tasks with inline checks against hand-computed values.
`timescale 1ns/1ps
module tb_mpu6050_i2c_slave;

    localparam int Q = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl = 1'b1;
    logic        m_low = 1'b0;
    wire         sda;
    logic [15:0] acc_x = '0, acc_y = '0, acc_z = '0, temp = '0;
    logic [15:0] gyro_x = '0, gyro_y = '0, gyro_z = '0;
    logic [7:0]  smplrt_div, config_reg, gyro_config, acc_config, pwr_mgmt_1;
    logic        wr_strobe, busy;
    logic [7:0]  wr_addr, wr_data;

    int          n_chk = 0;
    int          n_fail = 0;
    int          strobe_cnt = 0;
    logic [7:0]  last_wa = '0, last_wd = '0;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_strobe) begin
            strobe_cnt <= strobe_cnt + 1;
            last_wa    <= wr_addr;
            last_wd    <= wr_data;
        end
    end

    mpu6050_i2c_slave dut (
        .clk(clk), .rst(rst), .scl(scl), .sda(sda),
        .acc_x(acc_x), .acc_y(acc_y), .acc_z(acc_z), .temp(temp),
        .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
        .smplrt_div(smplrt_div), .config_reg(config_reg),
        .gyro_config(gyro_config), .acc_config(acc_config),
        .pwr_mgmt_1(pwr_mgmt_1), .wr_strobe(wr_strobe),
        .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    task automatic i2c_start();
        m_low = 1'b0; #Q;
        scl = 1'b1;   #Q;
        m_low = 1'b1; #Q;
        scl = 1'b0;   #Q;
    endtask

    task automatic i2c_stop();
        m_low = 1'b1; #Q;
        scl = 1'b1;   #Q;
        m_low = 1'b0; #Q;
    endtask

    task automatic bit_cycle(input logic drive_low, output logic seen);
        m_low = drive_low; #Q;
        scl = 1'b1;        #Q;
        seen = (sda === 1'b0) ? 1'b0 : 1'b1;
        #Q;
        scl = 1'b0;        #Q;
    endtask

    task automatic i2c_write(input logic [7:0] b, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) bit_cycle(~b[i], s);
        bit_cycle(1'b0, s);
        acked = ~s;
    endtask

    task automatic i2c_read(input logic send_ack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b0, s);
            b[i] = s;
        end
        bit_cycle(send_ack, s);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_chk++; if (smplrt_div !== 8'h00) begin n_fail++; $display("FAIL rst_smplrt got %h want 00", smplrt_div); end
        n_chk++; if (config_reg !== 8'h00) begin n_fail++; $display("FAIL rst_config got %h want 00", config_reg); end
        n_chk++; if (gyro_config !== 8'h00) begin n_fail++; $display("FAIL rst_gyro got %h want 00", gyro_config); end
        n_chk++; if (acc_config !== 8'h00) begin n_fail++; $display("FAIL rst_acc got %h want 00", acc_config); end
        n_chk++; if (pwr_mgmt_1 !== 8'h40) begin n_fail++; $display("FAIL rst_pwr got %h want 40", pwr_mgmt_1); end
        n_chk++; if (wr_strobe !== 1'b0) begin n_fail++; $display("FAIL rst_strobe got %b want 0", wr_strobe); end
        n_chk++; if ({wr_addr, wr_data} !== 16'h0000) begin n_fail++; $display("FAIL rst_wr got %h want 0000", {wr_addr, wr_data}); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
        n_chk++; if (sda !== 1'b1) begin n_fail++; $display("FAIL rst_sda got %b want 1", sda); end
        @(negedge clk);
        rst = 1'b0;
        #(4*Q);
    endtask

    task automatic test_single_write();
        logic a0, a1, a2;
        int c0;
        c0 = strobe_cnt;
        i2c_start();
        i2c_write(8'hD0, a0);
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t1_busy got %b want 1", busy); end
        i2c_write(8'h1B, a1);
        i2c_write(8'h18, a2);
        i2c_stop();
        #Q;
        n_chk++; if ({a0, a1, a2} !== 3'b111) begin n_fail++; $display("FAIL t1_acks got %b want 111", {a0, a1, a2}); end
        n_chk++; if (gyro_config !== 8'h18) begin n_fail++; $display("FAIL t1_gyro got %h want 18", gyro_config); end
        n_chk++; if (strobe_cnt - c0 !== 1) begin n_fail++; $display("FAIL t1_strobes got %0d want 1", strobe_cnt - c0); end
        n_chk++; if ({last_wa, last_wd} !== 16'h1B18) begin n_fail++; $display("FAIL t1_wr got %h want 1b18", {last_wa, last_wd}); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t1_busy_stop got %b want 0", busy); end
    endtask

    task automatic test_burst_write();
        logic a0, a1, a2, a3, ar;
        logic [7:0] rb;
        int c0;
        c0 = strobe_cnt;
        i2c_start();
        i2c_write(8'hD0, a0);
        i2c_write(8'h19, a1);
        i2c_write(8'h07, a2);
        i2c_write(8'h06, a3);
        i2c_stop();
        #Q;
        n_chk++; if ({a0, a1, a2, a3} !== 4'hF) begin n_fail++; $display("FAIL t2_acks got %b want 1111", {a0, a1, a2, a3}); end
        n_chk++; if (smplrt_div !== 8'h07) begin n_fail++; $display("FAIL t2_smplrt got %h want 07", smplrt_div); end
        n_chk++; if (config_reg !== 8'h06) begin n_fail++; $display("FAIL t2_config got %h want 06", config_reg); end
        n_chk++; if (strobe_cnt - c0 !== 2) begin n_fail++; $display("FAIL t2_strobes got %0d want 2", strobe_cnt - c0); end
        i2c_start();
        i2c_write(8'hD1, ar);
        i2c_read(1'b0, rb);
        i2c_stop();
        #Q;
        n_chk++; if (rb !== 8'h18) begin n_fail++; $display("FAIL t2_ptr_read got %h want 18", rb); end
    endtask

    task automatic test_burst_read();
        logic [7:0] exp_b [14];
        logic [7:0] rb;
        logic a0, a1, a2;
        int c0;
        exp_b = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE,
                  8'hF0, 8'h13, 8'h57, 8'h24, 8'h68, 8'hCD, 8'hEF};
        acc_x = 16'h1234; acc_y = 16'h5678; acc_z = 16'h9ABC;
        temp = 16'hDEF0;
        gyro_x = 16'h1357; gyro_y = 16'h2468; gyro_z = 16'hCDEF;
        c0 = strobe_cnt;
        i2c_start();
        i2c_write(8'hD0, a0);
        i2c_write(8'h3B, a1);
        i2c_start();
        i2c_write(8'hD1, a2);
        n_chk++; if ({a0, a1, a2} !== 3'b111) begin n_fail++; $display("FAIL t3_acks got %b want 111", {a0, a1, a2}); end
        for (int i = 0; i < 14; i++) begin
            i2c_read(i != 13, rb);
            n_chk++; if (rb !== exp_b[i]) begin n_fail++; $display("FAIL t3_byte%0d got %h want %h", i, rb, exp_b[i]); end
            if (i == 1) begin
                acc_x = 16'hFFFF; acc_y = 16'hFFFF; acc_z = 16'hFFFF;
                temp = 16'hFFFF; gyro_x = 16'hFFFF;
                gyro_y = 16'hFFFF; gyro_z = 16'hFFFF;
            end
        end
        n_chk++; if (sda !== 1'b1) begin n_fail++; $display("FAIL t3_sda_nack got %b want 1", sda); end
        i2c_stop();
        #Q;
        n_chk++; if (strobe_cnt - c0 !== 0) begin n_fail++; $display("FAIL t3_strobes got %0d want 0", strobe_cnt - c0); end
    endtask

    task automatic test_bad_addr();
        logic a0, a1;
        int c0;
        c0 = strobe_cnt;
        i2c_start();
        i2c_write(8'hD2, a0);
        n_chk++; if (a0 !== 1'b0) begin n_fail++; $display("FAIL t4_ack got %b want 0", a0); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t4_busy got %b want 0", busy); end
        i2c_write(8'h19, a1);
        i2c_write(8'h55, a1);
        n_chk++; if (a1 !== 1'b0) begin n_fail++; $display("FAIL t4_ignored_ack got %b want 0", a1); end
        i2c_stop();
        #Q;
        n_chk++; if (smplrt_div !== 8'h07) begin n_fail++; $display("FAIL t4_smplrt got %h want 07", smplrt_div); end
        n_chk++; if (strobe_cnt - c0 !== 0) begin n_fail++; $display("FAIL t4_strobes got %0d want 0", strobe_cnt - c0); end
    endtask

    task automatic test_soft_reset();
        logic a;
        logic [7:0] rb;
        i2c_start();
        i2c_write(8'hD0, a);
        i2c_write(8'h1C, a);
        i2c_write(8'h10, a);
        i2c_stop();
        #Q;
        n_chk++; if (acc_config !== 8'h10) begin n_fail++; $display("FAIL t5_acc_set got %h want 10", acc_config); end
        i2c_start();
        i2c_write(8'hD0, a);
        i2c_write(8'h6B, a);
        i2c_write(8'h80, a);
        i2c_stop();
        #Q;
        n_chk++; if ({smplrt_div, config_reg, gyro_config, acc_config} !== 32'h0)
            begin n_fail++; $display("FAIL t5_cfg got %h want 00000000", {smplrt_div, config_reg, gyro_config, acc_config}); end
        n_chk++; if (pwr_mgmt_1 !== 8'h40) begin n_fail++; $display("FAIL t5_pwr got %h want 40", pwr_mgmt_1); end
        i2c_start();
        i2c_write(8'hD0, a);
        i2c_write(8'h6B, a);
        i2c_start();
        i2c_write(8'hD1, a);
        i2c_read(1'b0, rb);
        i2c_stop();
        n_chk++; if (rb !== 8'h40) begin n_fail++; $display("FAIL t5_rd_pwr got %h want 40", rb); end
        i2c_start();
        i2c_write(8'hD0, a);
        i2c_write(8'h75, a);
        i2c_start();
        i2c_write(8'hD1, a);
        i2c_read(1'b0, rb);
        i2c_stop();
        n_chk++; if (rb !== 8'h68) begin n_fail++; $display("FAIL t5_whoami got %h want 68", rb); end
    endtask

    task automatic test_back_to_back();
        logic a;
        int c0;
        c0 = strobe_cnt;
        i2c_start();
        i2c_write(8'hD0, a);
        i2c_write(8'hFF, a);
        i2c_write(8'hAA, a);
        i2c_write(8'hBB, a);
        i2c_stop();
        #Q;
        n_chk++; if (strobe_cnt - c0 !== 2) begin n_fail++; $display("FAIL t7_strobes got %0d want 2", strobe_cnt - c0); end
        n_chk++; if ({last_wa, last_wd} !== 16'h00BB) begin n_fail++; $display("FAIL t7_wrap got %h want 00bb", {last_wa, last_wd}); end
        n_chk++; if (smplrt_div !== 8'h00) begin n_fail++; $display("FAIL t7_smplrt got %h want 00", smplrt_div); end
    endtask

    task automatic test_reset_mid_read();
        logic a;
        logic [7:0] rb;
        acc_x = 16'h00A5;
        i2c_start();
        i2c_write(8'hD0, a);
        i2c_write(8'h3B, a);
        i2c_start();
        i2c_write(8'hD1, a);
        n_chk++; if (sda !== 1'b0) begin n_fail++; $display("FAIL t6_driving got %b want 0", sda); end
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t6_busy_pre got %b want 1", busy); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_chk++; if (sda !== 1'b1) begin n_fail++; $display("FAIL t6_sda_rel got %b want 1", sda); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t6_busy got %b want 0", busy); end
        @(negedge clk);
        rst = 1'b0;
        #(2*Q);
        i2c_start();
        i2c_write(8'hD1, a);
        n_chk++; if (a !== 1'b1) begin n_fail++; $display("FAIL t6_ack got %b want 1", a); end
        i2c_read(1'b0, rb);
        i2c_stop();
        n_chk++; if (rb !== 8'h00) begin n_fail++; $display("FAIL t6_ptr0 got %h want 00", rb); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_burst_write();
        test_burst_read();
        test_bad_addr();
        test_soft_reset();
        test_back_to_back();
        test_reset_mid_read();
        #(4*Q);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
